// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch-stage types and defaults; the fetch entry is reused by the later
// decode pipeline registers.
package instruction_fetch_queue_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_PC_STEP  = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'd0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with synchronous flush; the head is
// zero whenever the queue is empty.
module instruction_fetch_queue_fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             clear;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign clear      = reset | flush;
    assign head_valid = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign pop_ok     = pop & head_valid;
    assign push_ok    = push & ~clear;
    assign head       = head_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !pop_ok && full));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: sequential PC generation, one outstanding imem read, buffered
// instruction queue toward decode, flushed by branch redirects.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter  int unsigned       DEPTH    = DEFAULT_DEPTH,
    parameter  logic [ADDR_W-1:0] PC_STEP  = DEFAULT_PC_STEP,
    parameter  logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               inst_ready,
    output logic [CNT_W-1:0]   queue_count
);

    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [OCC_W-1:0]  occupancy;
    logic              pop;
    fetch_entry_t      ret_entry;
    fetch_entry_t      head;

    // Queued plus outstanding entries; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, queue_count} + OCC_W'(inflight);
    assign imem_req  = ~reset & ~redirect_valid & (occupancy < OCC_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign ret_entry = '{pc: inflight_pc, instr: imem_rdata};
    assign pop       = inst_valid & inst_ready;
    assign inst      = head.instr;
    assign inst_pc   = head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight_pc <= fetch_pc;
            end
        end
    end

    instruction_fetch_queue_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (inflight),
        .push_data  (ret_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (inst_valid),
        .count      (queue_count)
    );

endmodule
